// File: rtl/branch_ctrl_if.sv
// Interface bundling the prediction lookup, execute-resolve, fetch-redirect and
// statistics signals of branch_ctrl.
interface branch_ctrl_if #(
    parameter int WIDTH = 32
);
    // Prediction lookup
    logic [WIDTH-1:0] fetch_pc;
    logic             pred_taken;

    // Execute-stage resolve handshake
    logic             ex_valid;
    logic             ex_ready;
    logic             ex_is_branch;
    logic             ex_branch_taken;
    logic             ex_pred_taken;
    logic [WIDTH-1:0] ex_pc;
    logic [WIDTH-1:0] ex_target;

    // Fetch redirect handshake and pipeline kill
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             redirect_ready;
    logic             flush;

    // Statistics
    logic [31:0]      branch_cnt;
    logic [31:0]      mispred_cnt;

    // The pipeline drives this side.
    modport master (
        output fetch_pc,
        input  pred_taken,
        output ex_valid,
        input  ex_ready,
        output ex_is_branch,
        output ex_branch_taken,
        output ex_pred_taken,
        output ex_pc,
        output ex_target,
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready,
        input  flush,
        input  branch_cnt,
        input  mispred_cnt
    );

    // branch_ctrl sits on this side.
    modport slave (
        input  fetch_pc,
        output pred_taken,
        input  ex_valid,
        output ex_ready,
        input  ex_is_branch,
        input  ex_branch_taken,
        input  ex_pred_taken,
        input  ex_pc,
        input  ex_target,
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready,
        output flush,
        output branch_cnt,
        output mispred_cnt
    );
endinterface

// File: rtl/branch_ctrl.sv
// Branch controller: 2-bit bimodal predictor, branch resolution, mispredict
// redirect handshake and a fixed-length flush pulse.
module branch_ctrl #(
    parameter int WIDTH        = 32,
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    branch_ctrl_if.slave  bus
);
    localparam int IDX = $clog2(BHT_ENTRIES);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REDIRECT = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [3:0]       flush_left;
    logic [3:0]       flush_left_nxt;
    logic [WIDTH-1:0] redirect_pc_q;
    logic [31:0]      branch_cnt_q;
    logic [31:0]      mispred_cnt_q;

    logic [1:0]       bht [BHT_ENTRIES];

    logic [IDX-1:0]   fetch_idx;
    logic [IDX-1:0]   upd_idx;
    logic             accept;
    logic             mispredict;
    logic [1:0]       upd_ctr;
    logic [1:0]       upd_ctr_nxt;

    assign fetch_idx  = bus.fetch_pc[IDX+1:2];
    assign upd_idx    = bus.ex_pc[IDX+1:2];
    assign accept     = bus.ex_valid && bus.ex_ready && bus.ex_is_branch;
    assign mispredict = accept && (bus.ex_branch_taken != bus.ex_pred_taken);

    // Lookup reads the array directly, so a same-cycle update of the entry
    // shows up only after the clock edge.
    assign bus.pred_taken = bht[fetch_idx][1];

    assign bus.ex_ready       = (state == S_IDLE);
    assign bus.redirect_valid = (state == S_REDIRECT);
    assign bus.flush          = (state == S_FLUSH);
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.mispred_cnt    = mispred_cnt_q;

    // Saturating 2-bit counter step for the resolving branch.
    assign upd_ctr = bht[upd_idx];
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        upd_ctr_nxt = upd_ctr;
        if (bus.ex_branch_taken) begin
            if (upd_ctr != 2'b11) upd_ctr_nxt = upd_ctr + 2'b01;
        end else begin
            if (upd_ctr != 2'b00) upd_ctr_nxt = upd_ctr - 2'b01;
        end
    end

    // NOTE: the BHT is a small flop array, not a RAM, so it can and must take
    // the weakly-not-taken reset value on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else if (accept) begin
            bht[upd_idx] <= upd_ctr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        flush_left_nxt = flush_left;
        case (state)
            S_IDLE: begin
                if (mispredict) state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (bus.redirect_ready) begin
                    state_nxt      = S_FLUSH;
                    flush_left_nxt = FLUSH_LAST;
                end
            end
            S_FLUSH: begin
                if (flush_left == 4'd0) state_nxt = S_IDLE;
                else                    flush_left_nxt = flush_left - 4'd1;
            end
            default: begin
                state_nxt      = S_IDLE;
                flush_left_nxt = 4'd0;
            end
        endcase
    end

    // NOTE: all state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            flush_left <= 4'd0;
        end else begin
            state      <= state_nxt;
            flush_left <= flush_left_nxt;
        end
    end

    // Restart address: the target if the branch really went, else fall-through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc_q <= '0;
        end else if (mispredict) begin
            redirect_pc_q <= bus.ex_branch_taken ? bus.ex_target
                                                 : bus.ex_pc + WIDTH'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q  <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else begin
            if (accept)     branch_cnt_q  <= branch_cnt_q + 32'd1;
            if (mispredict) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl: prediction, counter saturation,
// redirect handshake with back-pressure, PC wrap and reset abort.
module tb_branch_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    branch_ctrl_if #(.WIDTH(32)) bus ();

    branch_ctrl #(
        .WIDTH       (32),
        .BHT_ENTRIES (16),
        .FLUSH_CYCLES(2)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic valid, input logic is_br, input logic taken,
                            input logic pred, input logic [31:0] pc, input logic [31:0] tgt);
        bus.ex_valid        = valid;
        bus.ex_is_branch    = is_br;
        bus.ex_branch_taken = taken;
        bus.ex_pred_taken   = pred;
        bus.ex_pc           = pc;
        bus.ex_target       = tgt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.fetch_pc       = 32'h100;
        bus.redirect_ready = 1'b0;
        drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        repeat (3) tick();
        check("rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
        check("rst_flush",          64'(bus.flush),          64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Post-reset state
        check("post_ex_ready",    64'(bus.ex_ready),    64'd1);
        check("post_pred_100",    64'(bus.pred_taken),  64'd0);
        bus.fetch_pc = 32'h3C;
        #1;
        check("post_pred_3c",     64'(bus.pred_taken),  64'd0);
        check("post_branch_cnt",  64'(bus.branch_cnt),  64'd0);
        check("post_mispred_cnt", 64'(bus.mispred_cnt), 64'd0);
        check("post_redirect_pc", 64'(bus.redirect_pc), 64'd0);

        // redirect_ready outside REDIRECT must be ignored
        bus.redirect_ready = 1'b1;
        tick();
        check("idle_ready_ignored", 64'(bus.redirect_valid), 64'd0);
        bus.redirect_ready = 1'b0;

        // Three correctly predicted taken branches at 0x100: counter 1->2->3->3
        bus.fetch_pc = 32'h100;
        drive_ex(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h40);
        #1;
        check("same_cycle_pre_update", 64'(bus.pred_taken), 64'd0);
        tick();
        check("pred_after_first",  64'(bus.pred_taken), 64'd1);
        check("b2b_ex_ready",      64'(bus.ex_ready),   64'd1);
        tick();
        tick();
        drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("taken_branch_cnt",  64'(bus.branch_cnt),     64'd3);
        check("taken_mispred_cnt", 64'(bus.mispred_cnt),    64'd0);
        check("taken_stay_idle",   64'(bus.redirect_valid), 64'd0);
        bus.fetch_pc = 32'h140;
        #1;
        check("alias_idx0_pred",   64'(bus.pred_taken), 64'd1);
        bus.fetch_pc = 32'h104;
        #1;
        check("other_idx_pred",    64'(bus.pred_taken), 64'd0);

        // Accepted non-branch, even with mismatching flags, has no effect
        drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
        tick();
        drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("nonbr_branch_cnt",  64'(bus.branch_cnt),     64'd3);
        check("nonbr_no_redirect", 64'(bus.redirect_valid), 64'd0);

        // Two correct not-taken: 3->2 (still taken), 2->1 (not taken); proves saturation at 3
        bus.fetch_pc = 32'h100;
        drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        tick();
        check("sat_dec_3_to_2",   64'(bus.pred_taken), 64'd1);
        tick();
        drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("sat_dec_2_to_1",   64'(bus.pred_taken), 64'd0);
        check("nt_branch_cnt",    64'(bus.branch_cnt), 64'd5);

        // Taken mispredict at 0x200 (idx 0, counter 1->2) with redirect back-pressure
        drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h80);
        tick();
        // Keep a branch offered while busy: it must not be accepted
        drive_ex(1'b1, 1'b1, 1'b1, 1'b1, 32'h104, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rd_valid_c%0d", i),  64'(bus.redirect_valid), 64'd1);
            check($sformatf("rd_pc_c%0d", i),     64'(bus.redirect_pc),    64'h80);
            check($sformatf("rd_ready_c%0d", i),  64'(bus.ex_ready),       64'd0);
            check($sformatf("rd_flush_c%0d", i),  64'(bus.flush),          64'd0);
            tick();
        end
        drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.redirect_ready = 1'b1;
        #1;
        check("rd_valid_c3", 64'(bus.redirect_valid), 64'd1);
        check("rd_pc_c3",    64'(bus.redirect_pc),    64'h80);
        tick();
        bus.redirect_ready = 1'b0;
        check("flush_c0",       64'(bus.flush),          64'd1);
        check("flush_c0_rdv",   64'(bus.redirect_valid), 64'd0);
        check("flush_c0_ready", 64'(bus.ex_ready),       64'd0);
        tick();
        check("flush_c1",       64'(bus.flush),          64'd1);
        tick();
        check("flush_done",     64'(bus.flush),          64'd0);
        check("back_idle",      64'(bus.ex_ready),       64'd1);
        check("mp1_mispred_cnt", 64'(bus.mispred_cnt),   64'd1);
        check("mp1_branch_cnt",  64'(bus.branch_cnt),    64'd6);
        check("mp1_pred_100",    64'(bus.pred_taken),    64'd1);

        // Not-taken mispredict at the top of the address space: fall-through wraps
        bus.redirect_ready = 1'b1;
        drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234);
        tick();
        drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("wrap_rd_valid",    64'(bus.redirect_valid), 64'd1);
        check("wrap_rd_pc",       64'(bus.redirect_pc),    64'h0);
        check("wrap_mispred_cnt", 64'(bus.mispred_cnt),    64'd2);
        tick();
        bus.redirect_ready = 1'b0;
        check("wrap_flush", 64'(bus.flush), 64'd1);

        // Asynchronous reset mid-FLUSH aborts immediately
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_flush",    64'(bus.flush),          64'd0);
        check("abort_rd_valid", 64'(bus.redirect_valid), 64'd0);
        check("abort_ex_ready", 64'(bus.ex_ready),       64'd1);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rel_branch_cnt",  64'(bus.branch_cnt),  64'd0);
        check("rel_mispred_cnt", 64'(bus.mispred_cnt), 64'd0);
        check("rel_redirect_pc", 64'(bus.redirect_pc), 64'd0);
        check("rel_pred_100",    64'(bus.pred_taken),  64'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rel_no_flush_%0d", i), 64'({bus.flush, bus.redirect_valid}), 64'd0);
            tick();
        end
        // One taken update must move the reset counter from 1 to 2
        drive_ex(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h0);
        tick();
        drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rel_bht_weak", 64'(bus.pred_taken), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
